// File: rtl/cache_axi_pkg.sv
// Shared constants for cache_axi_arbiter: requester indices, FSM state codes, fixed AXI attributes.
package cache_axi_pkg;

   localparam int unsigned REQ_ICACHE  = 0;
   localparam int unsigned REQ_DCACHE  = 1;
   localparam int unsigned REQ_UNCACHE = 2;

   // write-side requester indices (dcache, uncache)
   localparam int unsigned WR_DCACHE   = 0;
   localparam int unsigned WR_UNCACHE  = 1;

   localparam int unsigned N_RD = 3;
   localparam int unsigned N_WR = 2;

   localparam logic [1:0] R_IDLE = 2'd0;
   localparam logic [1:0] R_ADDR = 2'd1;
   localparam logic [1:0] R_DATA = 2'd2;

   localparam logic [1:0] W_IDLE = 2'd0;
   localparam logic [1:0] W_ADDR = 2'd1;
   localparam logic [1:0] W_DATA = 2'd2;
   localparam logic [1:0] W_RESP = 2'd3;

   localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
   localparam logic [1:0] AXI_BURST_INCR = 2'b01;

endpackage

// File: rtl/cache_axi_arbiter_rr_arbiter.sv
// N-way grant picker with latched grant; round-robin pointer advances on completion.
// CACHE_AXI_ARB_FIXED_PRIO_EN: PRIO_IDX first, then ascending index, no pointer.
module rr_arbiter #(
   parameter int unsigned N        = 2,
   parameter int unsigned PRIO_IDX = 0
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic [N-1:0]         req,
   input  logic                 take,
   input  logic                 done,
   output logic [N-1:0]         gnt,
   output logic [$clog2(N)-1:0] gnt_idx
);
   localparam int unsigned PW = $clog2(N);

   logic [PW-1:0] pick_idx;

`ifdef CACHE_AXI_ARB_FIXED_PRIO_EN
   logic unused_done;
   assign unused_done = done;

   always_comb begin
      pick_idx = PW'(PRIO_IDX);
      if (!req[PW'(PRIO_IDX)]) begin
         for (int i = N - 1; i >= 0; i--) begin
            if (req[PW'(i)]) pick_idx = PW'(i);
         end
      end
   end
`else
   logic [PW-1:0] ptr;
   int            idx;
   logic          found;

   // first requester at or after ptr, wrapping
   always_comb begin
      pick_idx = '0;
      found    = 1'b0;
      idx      = 0;
      for (int k = 0; k < N; k++) begin
         idx = int'(ptr) + k;
         if (idx >= int'(N)) idx = idx - int'(N);
         if (!found && req[PW'(idx)]) begin
            pick_idx = PW'(idx);
            found    = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn)   ptr <= '0;
      else if (done) ptr <= (gnt_idx == PW'(N - 1)) ? '0 : gnt_idx + PW'(1);
   end
`endif

   always_ff @(posedge clk) begin
      if (!resetn)   gnt_idx <= '0;
      else if (take) gnt_idx <= pick_idx;
   end

   always_comb begin
      for (int i = 0; i < N; i++) gnt[i] = (gnt_idx == PW'(i));
   end

endmodule

// File: rtl/cache_axi_arbiter.sv
// Shares one AXI master among icache/dcache/uncache: 3-way AR/R, 2-way AW/W/B, one outstanding each.
// Grant policy is round-robin unless CACHE_AXI_ARB_FIXED_PRIO_EN is defined.
module cache_axi_arbiter
   import cache_axi_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ID_W   = 4
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic [N_RD-1:0]          s_arvalid,
   input  logic [N_RD*ADDR_W-1:0]   s_araddr,
   input  logic [N_RD*8-1:0]        s_arlen,
   output logic [N_RD-1:0]          s_arready,
   output logic [N_RD-1:0]          s_rvalid,
   input  logic [N_RD-1:0]          s_rready,
   output logic [DATA_W-1:0]        s_rdata,
   output logic                     s_rlast,
   input  logic [N_WR-1:0]          s_awvalid,
   input  logic [N_WR*ADDR_W-1:0]   s_awaddr,
   input  logic [N_WR*8-1:0]        s_awlen,
   output logic [N_WR-1:0]          s_awready,
   input  logic [N_WR-1:0]          s_wvalid,
   input  logic [N_WR*DATA_W-1:0]   s_wdata,
   input  logic [N_WR-1:0]          s_wlast,
   output logic [N_WR-1:0]          s_wready,
   output logic [N_WR-1:0]          s_bvalid,
   input  logic [N_WR-1:0]          s_bready,
   output logic [1:0]               s_bresp,
   output logic [ID_W-1:0]          m_arid,
   output logic [ADDR_W-1:0]        m_araddr,
   output logic [7:0]               m_arlen,
   output logic [2:0]               m_arsize,
   output logic [1:0]               m_arburst,
   output logic                     m_arvalid,
   input  logic                     m_arready,
   input  logic [ID_W-1:0]          m_rid,
   input  logic [DATA_W-1:0]        m_rdata,
   input  logic [1:0]               m_rresp,
   input  logic                     m_rlast,
   input  logic                     m_rvalid,
   output logic                     m_rready,
   output logic [ID_W-1:0]          m_awid,
   output logic [ADDR_W-1:0]        m_awaddr,
   output logic [7:0]               m_awlen,
   output logic [2:0]               m_awsize,
   output logic [1:0]               m_awburst,
   output logic                     m_awvalid,
   input  logic                     m_awready,
   output logic [DATA_W-1:0]        m_wdata,
   output logic [3:0]               m_wstrb,
   output logic                     m_wlast,
   output logic                     m_wvalid,
   input  logic                     m_wready,
   input  logic [ID_W-1:0]          m_bid,
   input  logic [1:0]               m_bresp,
   input  logic                     m_bvalid,
   output logic                     m_bready
);

   logic [1:0]        r_state, r_state_nxt, w_state, w_state_nxt;
   logic [N_RD-1:0]   r_req, r_gnt;
   logic [N_WR-1:0]   w_req, w_gnt;
   logic [1:0]        rg;
   logic [0:0]        wg;
   logic              r_take, r_done, w_take, w_done;

   logic [ADDR_W-1:0] araddr_a [N_RD];
   logic [7:0]        arlen_a  [N_RD];
   logic [ADDR_W-1:0] awaddr_a [N_WR];
   logic [7:0]        awlen_a  [N_WR];
   logic [DATA_W-1:0] wdata_a  [N_WR];

   // routing uses the latched grant only, so response IDs are not needed
   logic unused_ids;
   assign unused_ids = ^{m_rid, m_rresp, m_bid};

   for (genvar i = 0; i < N_RD; i++) begin : g_rd_slice
      assign araddr_a[i] = s_araddr[i*ADDR_W +: ADDR_W];
      assign arlen_a[i]  = s_arlen[i*8 +: 8];
   end

   for (genvar i = 0; i < N_WR; i++) begin : g_wr_slice
      assign awaddr_a[i] = s_awaddr[i*ADDR_W +: ADDR_W];
      assign awlen_a[i]  = s_awlen[i*8 +: 8];
      assign wdata_a[i]  = s_wdata[i*DATA_W +: DATA_W];
   end

   // MMIO ordering: uncache read waits for the write path, uncache write waits for an uncache read
   always_comb begin
      r_req              = s_arvalid;
      r_req[REQ_UNCACHE] = s_arvalid[REQ_UNCACHE] && (w_state == W_IDLE);
      w_req              = s_awvalid;
      w_req[WR_UNCACHE]  = s_awvalid[WR_UNCACHE] &&
                           !((r_state != R_IDLE) && (rg == 2'(REQ_UNCACHE)));
   end

   rr_arbiter #(.N(N_RD), .PRIO_IDX(REQ_DCACHE)) u_rd_arb (
      .clk     (clk),
      .resetn  (resetn),
      .req     (r_req),
      .take    (r_take),
      .done    (r_done),
      .gnt     (r_gnt),
      .gnt_idx (rg)
   );

   rr_arbiter #(.N(N_WR), .PRIO_IDX(WR_DCACHE)) u_wr_arb (
      .clk     (clk),
      .resetn  (resetn),
      .req     (w_req),
      .take    (w_take),
      .done    (w_done),
      .gnt     (w_gnt),
      .gnt_idx (wg)
   );

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state <= R_IDLE;
         w_state <= W_IDLE;
      end else begin
         r_state <= r_state_nxt;
         w_state <= w_state_nxt;
      end
   end

   assign m_arid    = ID_W'(rg);
   assign m_araddr  = araddr_a[rg];
   assign m_arlen   = arlen_a[rg];
   assign m_arsize  = AXI_SIZE_4B;
   assign m_arburst = AXI_BURST_INCR;
   assign s_rdata   = m_rdata;
   assign s_rlast   = m_rlast;

   assign m_awid    = ID_W'({1'b0, wg} + 2'd1);
   assign m_awaddr  = awaddr_a[wg];
   assign m_awlen   = awlen_a[wg];
   assign m_awsize  = AXI_SIZE_4B;
   assign m_awburst = AXI_BURST_INCR;
   assign m_wdata   = wdata_a[wg];
   assign m_wlast   = s_wlast[wg];
   assign m_wstrb   = 4'hF;
   assign s_bresp   = m_bresp;

   // read FSM: grant, forward AR, forward R until the last beat
   always_comb begin
      r_state_nxt = r_state;
      r_take      = 1'b0;
      r_done      = 1'b0;
      m_arvalid   = 1'b0;
      s_arready   = '0;
      s_rvalid    = '0;
      m_rready    = 1'b0;
      case (r_state)
         R_IDLE: begin
            if (|r_req) begin
               r_take      = 1'b1;
               r_state_nxt = R_ADDR;
            end
         end
         R_ADDR: begin
            m_arvalid = s_arvalid[rg];
            s_arready = r_gnt & {N_RD{m_arready}};
            if (m_arvalid && m_arready) r_state_nxt = R_DATA;
         end
         R_DATA: begin
            s_rvalid = r_gnt & {N_RD{m_rvalid}};
            m_rready = s_rready[rg];
            if (m_rvalid && m_rready && m_rlast) begin
               r_done      = 1'b1;
               r_state_nxt = R_IDLE;
            end
         end
         default: r_state_nxt = R_IDLE;
      endcase
   end

   // write FSM: grant, forward AW, W burst, then B
   always_comb begin
      w_state_nxt = w_state;
      w_take      = 1'b0;
      w_done      = 1'b0;
      m_awvalid   = 1'b0;
      s_awready   = '0;
      m_wvalid    = 1'b0;
      s_wready    = '0;
      s_bvalid    = '0;
      m_bready    = 1'b0;
      case (w_state)
         W_IDLE: begin
            if (|w_req) begin
               w_take      = 1'b1;
               w_state_nxt = W_ADDR;
            end
         end
         W_ADDR: begin
            m_awvalid = s_awvalid[wg];
            s_awready = w_gnt & {N_WR{m_awready}};
            if (m_awvalid && m_awready) w_state_nxt = W_DATA;
         end
         W_DATA: begin
            m_wvalid = s_wvalid[wg];
            s_wready = w_gnt & {N_WR{m_wready}};
            if (m_wvalid && m_wready && s_wlast[wg]) w_state_nxt = W_RESP;
         end
         W_RESP: begin
            s_bvalid = w_gnt & {N_WR{m_bvalid}};
            m_bready = s_bready[wg];
            if (m_bvalid && m_bready) begin
               w_done      = 1'b1;
               w_state_nxt = W_IDLE;
            end
         end
         default: w_state_nxt = W_IDLE;
      endcase
   end

endmodule

// File: tb/tb_cache_axi_arbiter.sv
// Directed bench for cache_axi_arbiter: table of read-arbitration vectors plus write, MMIO, stall and reset sequences.
module tb_cache_axi_arbiter;

   logic        clk;
   logic        resetn;
   logic [2:0]  s_arvalid, s_arready, s_rvalid, s_rready;
   logic [95:0] s_araddr;
   logic [23:0] s_arlen;
   logic [31:0] s_rdata;
   logic        s_rlast;
   logic [1:0]  s_awvalid, s_awready, s_wvalid, s_wlast, s_wready, s_bvalid, s_bready, s_bresp;
   logic [63:0] s_awaddr, s_wdata;
   logic [15:0] s_awlen;
   logic [3:0]  m_arid, m_rid, m_awid, m_bid, m_wstrb;
   logic [31:0] m_araddr, m_rdata, m_awaddr, m_wdata;
   logic [7:0]  m_arlen, m_awlen;
   logic [2:0]  m_arsize, m_awsize;
   logic [1:0]  m_arburst, m_awburst, m_rresp, m_bresp;
   logic        m_arvalid, m_arready, m_rlast, m_rvalid, m_rready;
   logic        m_awvalid, m_awready, m_wlast, m_wvalid, m_wready, m_bvalid, m_bready;

   cache_axi_arbiter dut (
      .clk(clk), .resetn(resetn),
      .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arready(s_arready),
      .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rlast(s_rlast),
      .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awready(s_awready),
      .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wlast(s_wlast), .s_wready(s_wready),
      .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
      .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
      .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
      .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
      .m_rvalid(m_rvalid), .m_rready(m_rready),
      .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
      .m_awburst(m_awburst), .m_awvalid(m_awvalid), .m_awready(m_awready),
      .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid),
      .m_wready(m_wready), .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid),
      .m_bready(m_bready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0] mask;   // requesters raising arvalid together
      logic [7:0] len;
      logic [1:0] o0;     // expected grant order, 3 = none
      logic [1:0] o1;
      logic [1:0] o2;
   } rd_vec_t;

   rd_vec_t     vecs [5];
   rd_vec_t     post_rst;
   logic [31:0] rd_addr [3];
   int          n_chk = 0;
   int          n_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_read(input rd_vec_t v);
      logic [2:0]  pend;
      logic [1:0]  g;
      logic [31:0] d;
      int          t;
      pend      = v.mask;
      s_arlen   = {3{v.len}};
      s_arvalid = pend;
      for (int k = 0; k < 3; k++) begin
         g = (k == 0) ? v.o0 : (k == 1) ? v.o1 : v.o2;
         if (g == 2'd3) break;
         t = 0;
         @(negedge clk);
         while (!m_arvalid && t < 20) begin
            t++;
            @(negedge clk);
         end
         chk("ar_timeout", m_arvalid, 1'b1);
         if (!m_arvalid) begin
            s_arvalid = '0;
            return;
         end
         chk("ar_latency", t, (k == 0) ? 1 : 0);
         chk("arid", m_arid, g);
         chk("araddr", m_araddr, rd_addr[g]);
         chk("arlen", m_arlen, v.len);
         chk("s_arready", s_arready, 3'b001 << g);
         step();
         pend[g]   = 1'b0;
         s_arvalid = pend;
         s_rready  = 3'b111;
         for (int b = 0; b <= int'(v.len); b++) begin
            d       = 32'hD000_0000 | (32'(g) << 8) | 32'(b);
            m_rvalid = 1'b1;
            m_rdata  = d;
            m_rlast  = (b == int'(v.len));
            @(negedge clk);
            chk("s_rvalid", s_rvalid, 3'b001 << g);
            chk("m_rready", m_rready, 1'b1);
            chk("s_rdata", s_rdata, d);
            step();
         end
         // stray beat in R_IDLE must not be accepted
         m_rlast = 1'b0;
         @(negedge clk);
         chk("idle_rready", m_rready, 1'b0);
         chk("idle_rvalid", s_rvalid, 3'b000);
         step();
         m_rvalid = 1'b0;
      end
      s_arvalid = '0;
      s_rready  = '0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int          t;
      logic [31:0] wd;

      rd_addr[0] = 32'h1C00_0000;
      rd_addr[1] = 32'h8000_1000;
      rd_addr[2] = 32'hBFD0_0000;
`ifdef CACHE_AXI_ARB_FIXED_PRIO_EN
      vecs[0]  = '{mask: 3'b011, len: 8'd1, o0: 2'd1, o1: 2'd0, o2: 2'd3};
      vecs[1]  = '{mask: 3'b001, len: 8'd3, o0: 2'd0, o1: 2'd3, o2: 2'd3};
      vecs[2]  = '{mask: 3'b011, len: 8'd0, o0: 2'd1, o1: 2'd0, o2: 2'd3};
      vecs[3]  = '{mask: 3'b100, len: 8'd0, o0: 2'd2, o1: 2'd3, o2: 2'd3};
      vecs[4]  = '{mask: 3'b111, len: 8'd0, o0: 2'd1, o1: 2'd0, o2: 2'd2};
      post_rst = '{mask: 3'b011, len: 8'd0, o0: 2'd1, o1: 2'd0, o2: 2'd3};
`else
      vecs[0]  = '{mask: 3'b011, len: 8'd1, o0: 2'd0, o1: 2'd1, o2: 2'd3};
      vecs[1]  = '{mask: 3'b001, len: 8'd3, o0: 2'd0, o1: 2'd3, o2: 2'd3};
      vecs[2]  = '{mask: 3'b011, len: 8'd0, o0: 2'd1, o1: 2'd0, o2: 2'd3};
      vecs[3]  = '{mask: 3'b100, len: 8'd0, o0: 2'd2, o1: 2'd3, o2: 2'd3};
      vecs[4]  = '{mask: 3'b111, len: 8'd0, o0: 2'd0, o1: 2'd1, o2: 2'd2};
      post_rst = '{mask: 3'b011, len: 8'd0, o0: 2'd0, o1: 2'd1, o2: 2'd3};
`endif

      // reset with every request and response valid asserted
      resetn    = 1'b0;
      s_araddr  = {rd_addr[2], rd_addr[1], rd_addr[0]};
      s_arlen   = '0;
      s_arvalid = 3'b111;
      s_rready  = 3'b111;
      s_awaddr  = {32'hBFD0_1000, 32'h8000_2000};
      s_awlen   = '0;
      s_awvalid = 2'b11;
      s_wvalid  = 2'b11;
      s_wdata   = '0;
      s_wlast   = 2'b11;
      s_bready  = 2'b11;
      m_arready = 1'b1;
      m_rid     = '0;
      m_rdata   = '0;
      m_rresp   = '0;
      m_rlast   = 1'b1;
      m_rvalid  = 1'b1;
      m_awready = 1'b1;
      m_wready  = 1'b1;
      m_bid     = '0;
      m_bresp   = '0;
      m_bvalid  = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_arvalid", m_arvalid, 1'b0);
      chk("rst_s_arready", s_arready, 3'b000);
      chk("rst_rready", m_rready, 1'b0);
      chk("rst_s_rvalid", s_rvalid, 3'b000);
      chk("rst_awvalid", m_awvalid, 1'b0);
      chk("rst_wvalid", m_wvalid, 1'b0);
      chk("rst_bready", m_bready, 1'b0);
      chk("rst_s_bvalid", s_bvalid, 2'b00);
      chk("arsize", m_arsize, 3'b010);
      chk("arburst", m_arburst, 2'b01);
      chk("wstrb", m_wstrb, 4'hF);
      step();
      resetn    = 1'b1;
      s_arvalid = '0;
      s_rready  = '0;
      s_awvalid = '0;
      s_wvalid  = '0;
      s_wlast   = '0;
      s_bready  = '0;
      m_rvalid  = 1'b0;
      m_rlast   = 1'b0;
      m_bvalid  = 1'b0;
      step();

      for (int i = 0; i < 5; i++) run_read(vecs[i]);

      // dcache write burst of four beats
      s_awlen   = {8'd0, 8'd3};
      s_awvalid = 2'b01;
      t = 0;
      @(negedge clk);
      while (!m_awvalid && t < 20) begin
         t++;
         @(negedge clk);
      end
      chk("aw_timeout", m_awvalid, 1'b1);
      chk("awid_dcache", m_awid, 4'd1);
      chk("awaddr", m_awaddr, 32'h8000_2000);
      chk("awlen", m_awlen, 8'd3);
      chk("s_awready", s_awready, 2'b01);
      chk("awsize", m_awsize, 3'b010);
      chk("awburst", m_awburst, 2'b01);
      step();
      s_awvalid = '0;
      for (int b = 0; b < 4; b++) begin
         wd       = 32'h11 * 32'(b + 1);
         s_wvalid = 2'b01;
         s_wdata  = {32'h0, wd};
         s_wlast  = {1'b0, b == 3};
         @(negedge clk);
         chk("m_wvalid", m_wvalid, 1'b1);
         chk("m_wdata", m_wdata, wd);
         chk("m_wlast", m_wlast, b == 3);
         chk("s_wready", s_wready, 2'b01);
         step();
      end
      s_wvalid = '0;
      s_wlast  = '0;
      m_bvalid = 1'b1;
      m_bresp  = 2'b10;
      s_bready = 2'b01;
      @(negedge clk);
      chk("s_bvalid", s_bvalid, 2'b01);
      chk("m_bready", m_bready, 1'b1);
      chk("s_bresp_slverr", s_bresp, 2'b10);
      step();
      @(negedge clk);
      chk("w_idle_bready", m_bready, 1'b0);
      chk("w_idle_bvalid", s_bvalid, 2'b00);
      step();
      m_bvalid = 1'b0;
      m_bresp  = 2'b00;
      s_bready = '0;

      // uncache read held off while an uncache write is in flight
      s_awlen   = '0;
      s_awvalid = 2'b10;
      t = 0;
      @(negedge clk);
      while (!m_awvalid && t < 20) begin
         t++;
         @(negedge clk);
      end
      chk("aw_unc_timeout", m_awvalid, 1'b1);
      chk("awid_uncache", m_awid, 4'd2);
      step();
      s_awvalid = '0;
      s_arlen   = '0;
      s_arvalid = 3'b100;
      repeat (3) begin
         @(negedge clk);
         chk("mmio_hold_wdata", m_arvalid, 1'b0);
         step();
      end
      s_wvalid = 2'b10;
      s_wdata  = {32'hCAFE_0001, 32'h0};
      s_wlast  = 2'b10;
      @(negedge clk);
      chk("unc_wdata", m_wdata, 32'hCAFE_0001);
      chk("unc_s_wready", s_wready, 2'b10);
      step();
      s_wvalid = '0;
      s_wlast  = '0;
      repeat (2) begin
         @(negedge clk);
         chk("mmio_hold_resp", m_arvalid, 1'b0);
         step();
      end
      m_bvalid = 1'b1;
      s_bready = 2'b10;
      @(negedge clk);
      chk("unc_s_bvalid", s_bvalid, 2'b10);
      chk("mmio_hold_bhs", m_arvalid, 1'b0);
      step();
      m_bvalid = 1'b0;
      s_bready = '0;
      @(negedge clk);
      chk("mmio_grant_cycle", m_arvalid, 1'b0);
      step();
      @(negedge clk);
      chk("mmio_ar_released", m_arvalid, 1'b1);
      chk("mmio_arid", m_arid, 4'd2);
      chk("mmio_araddr", m_araddr, 32'hBFD0_0000);
      step();
      s_arvalid = '0;
      m_rvalid  = 1'b1;
      m_rlast   = 1'b1;
      s_rready  = 3'b100;
      @(negedge clk);
      chk("mmio_s_rvalid", s_rvalid, 3'b100);
      step();
      m_rvalid = 1'b0;
      m_rlast  = 1'b0;
      s_rready = '0;

      // AR stall then R stall on icache
      s_arlen   = {3{8'd1}};
      s_arvalid = 3'b001;
      m_arready = 1'b0;
      step();
      repeat (5) begin
         @(negedge clk);
         chk("stall_arvalid", m_arvalid, 1'b1);
         chk("stall_araddr", m_araddr, 32'h1C00_0000);
         chk("stall_s_arready", s_arready, 3'b000);
         step();
      end
      m_arready = 1'b1;
      @(negedge clk);
      chk("stall_ar_hs", s_arready, 3'b001);
      step();
      s_arvalid = '0;
      m_rvalid  = 1'b1;
      m_rlast   = 1'b0;
      s_rready  = 3'b000;
      repeat (3) begin
         @(negedge clk);
         chk("stall_rready", m_rready, 1'b0);
         chk("stall_s_rvalid", s_rvalid, 3'b001);
         step();
      end
      s_rready = 3'b001;
      @(negedge clk);
      chk("stall_rready_go", m_rready, 1'b1);
      step();
      m_rlast = 1'b1;
      @(negedge clk);
      chk("stall_last", m_rready, 1'b1);
      step();
      m_rvalid = 1'b0;
      m_rlast  = 1'b0;
      s_rready = '0;

      // reset in the middle of an icache burst
      s_arlen   = {3{8'd3}};
      s_arvalid = 3'b001;
      step();
      step();
      s_arvalid = '0;
      m_rvalid  = 1'b1;
      s_rready  = 3'b001;
      @(negedge clk);
      chk("pre_rst_rready", m_rready, 1'b1);
      step();
      resetn = 1'b0;
      step();
      resetn = 1'b1;
      @(negedge clk);
      chk("mid_rst_rready", m_rready, 1'b0);
      chk("mid_rst_s_rvalid", s_rvalid, 3'b000);
      chk("mid_rst_arvalid", m_arvalid, 1'b0);
      chk("mid_rst_s_arready", s_arready, 3'b000);
      step();
      m_rvalid = 1'b0;
      s_rready = '0;
      run_read(post_rst);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
